// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: start/run/drain/halt sequencing plus hazard, redirect
// and return-stack control for the 5-stage core.
// Optional: define ZERO_REG_EN to treat r0 as hardwired zero, so a load to
// r0 never causes a load-use stall.
module pipeline_sequencer #(
  parameter int STACK_DEPTH  = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       id_halt,
  input  logic       id_jmp,
  input  logic       id_call,
  input  logic       id_ret,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_rd,
  input  logic [2:0] ex_rd,
  input  logic       ex_branch_taken,
  output logic [1:0] pc_sel,
  output logic       pc_wr,
  output logic       if_id_wr,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       push,
  output logic       pop,
  output logic       running,
  output logic       halted,
  output logic       fault
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int DRN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(STACK_DEPTH);
  localparam logic [DRN_W-1:0]   DRAIN_INIT = DRN_W'(DRAIN_CYCLES - 1);

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_JMP = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_BR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [DRN_W-1:0]     drain_q, drain_d;
  logic                 fault_q, fault_d;
  logic                 rd_live;
  logic                 load_use;
  logic                 do_halt;

`ifdef ZERO_REG_EN
  assign rd_live = (ex_rd != 3'd0);
`else
  assign rd_live = 1'b1;
`endif

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = ex_mem_rd & rd_live &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  assign running = (state_q == S_RUN);
  assign halted  = (state_q == S_HALTED);
  assign fault   = fault_q;

  // Next-state and same-cycle pipeline controls; non-RUN states freeze the front end.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    drain_d     = drain_q;
    fault_d     = fault_q;
    pc_sel      = SEL_INC;
    pc_wr       = 1'b0;
    if_id_wr    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    push        = 1'b0;
    pop         = 1'b0;
    do_halt     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        pc_wr       = 1'b1;
        if_id_wr    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (ex_branch_taken) begin
          // Redirect kills whatever sits in ID, including control flow.
          pc_sel      = SEL_BR;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_halt) begin
          do_halt = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF_ID, bubble into EX; ID jmp/call/ret retry next cycle.
          pc_wr       = 1'b0;
          if_id_wr    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_call) begin
          if (depth_q == DEPTH_MAX) begin
            fault_d = 1'b1;
            do_halt = 1'b1;
          end else begin
            pc_sel      = SEL_JMP;
            push        = 1'b1;
            if_id_flush = 1'b1;
            depth_d     = depth_q + 1'b1;
          end
        end else if (id_ret) begin
          if (depth_q == '0) begin
            fault_d = 1'b1;
            do_halt = 1'b1;
          end else begin
            pc_sel      = SEL_STK;
            pop         = 1'b1;
            if_id_flush = 1'b1;
            depth_d     = depth_q - 1'b1;
          end
        end else if (id_jmp) begin
          pc_sel      = SEL_JMP;
          if_id_flush = 1'b1;
        end
        if (do_halt) begin
          pc_wr       = 1'b0;
          if_id_flush = 1'b1;
          drain_d     = DRAIN_INIT;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_HALTED;
        else               drain_d = drain_q - 1'b1;
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, call depth, drain countdown and sticky fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      drain_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      drain_q <= drain_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed + random stimulus, reference model feeding a
// scoreboard queue, monitor comparing on the falling clock edge.
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, id_halt, id_jmp, id_call, id_ret;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_rd, ex_branch_taken;
  logic [1:0] pc_sel;
  logic       pc_wr, if_id_wr, if_id_flush, id_ex_flush, push, pop, running, halted, fault;

  pipeline_sequencer #(.STACK_DEPTH(8), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .id_halt(id_halt), .id_jmp(id_jmp), .id_call(id_call), .id_ret(id_ret),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .pc_sel(pc_sel), .pc_wr(pc_wr), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .push(push), .pop(pop), .running(running),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, start, halt, jmp, call, ret;
    logic [2:0] rs, rt, rd;
    logic urs, urt, mrd, br;
  } stim_t;

  typedef struct {
    logic [10:0] v;   // {pc_sel,pc_wr,if_id_wr,if_id_flush,id_ex_flush,push,pop,running,halted,fault}
    string       tag;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  string phase = "reset";

  // Reference model: abstract sequencer state.
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HALTED} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_depth = 0;
  int      m_left  = 0;   // DRAIN cycles still to spend
  bit      m_fault = 0;

  function automatic stim_t quiet();
    stim_t s;
    s = '{rst:1'b1, start:1'b0, halt:1'b0, jmp:1'b0, call:1'b0, ret:1'b0,
          rs:3'd0, rt:3'd0, rd:3'd0, urs:1'b0, urt:1'b0, mrd:1'b0, br:1'b0};
    return s;
  endfunction

  task automatic model(input stim_t s, output logic [10:0] e);
    int  sel;
    bit  pw, iw, f1, f2, pu, po, hz, go_halt;
    sel = 0; pw = 0; iw = 0; f1 = 1; f2 = 1; pu = 0; po = 0; go_halt = 0;
    if (!s.rst) begin
      m_state = M_IDLE; m_depth = 0; m_left = 0; m_fault = 0;
      e = {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      return;
    end
    e = {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_state == M_RUN, m_state == M_HALTED, m_fault};
    case (m_state)
      M_IDLE: if (s.start) m_state = M_RUN;
      M_HALTED: ;
      M_DRAIN: begin
        m_left--;
        if (m_left == 0) m_state = M_HALTED;
      end
      M_RUN: begin
        pw = 1; iw = 1; f1 = 0; f2 = 0;
        hz = s.mrd && ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
`ifdef ZERO_REG_EN
        if (s.rd == 0) hz = 0;
`endif
        if (s.br) begin sel = 3; f1 = 1; f2 = 1; end
        else if (s.halt) go_halt = 1;
        else if (hz) begin pw = 0; iw = 0; f2 = 1; end
        else if (s.call) begin
          if (m_depth == 8) begin m_fault = 1; go_halt = 1; end
          else begin sel = 1; pu = 1; f1 = 1; m_depth++; end
        end else if (s.ret) begin
          if (m_depth == 0) begin m_fault = 1; go_halt = 1; end
          else begin sel = 2; po = 1; f1 = 1; m_depth--; end
        end else if (s.jmp) begin sel = 1; f1 = 1; end
        if (go_halt) begin pw = 0; f1 = 1; m_state = M_DRAIN; m_left = 3; end
        e[10:2] = {2'(sel), pw, iw, f1, f2, pu, po, 1'b1};
      end
      default: ;
    endcase
  endtask

  // Apply one cycle of stimulus just after the rising edge; queue the expectation.
  task automatic drive(input stim_t s);
    exp_t x;
    @(posedge clk); #1;
    rst = s.rst; start = s.start; id_halt = s.halt; id_jmp = s.jmp; id_call = s.call;
    id_ret = s.ret; id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
    ex_mem_rd = s.mrd; ex_rd = s.rd; ex_branch_taken = s.br;
    model(s, x.v);
    x.tag = phase;
    sb.push_back(x);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(quiet());
  endtask

  task automatic do_reset_start();
    stim_t s;
    s = quiet(); s.rst = 1'b0; drive(s);
    idle_n(2);
    s = quiet(); s.start = 1'b1; drive(s);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t x;
    logic [10:0] act;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      act = {pc_sel, pc_wr, if_id_wr, if_id_flush, id_ex_flush, push, pop, running, halted, fault};
      checks++;
      if (act !== x.v) begin
        failures++;
        $display("FAIL %s t=%0t outputs got=%b want=%b (pc_sel,pc_wr,if_id_wr,ifl,efl,push,pop,run,halt,fault)",
                 x.tag, $time, act, x.v);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0; start = 0; id_halt = 0; id_jmp = 0; id_call = 0; id_ret = 0;
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; ex_mem_rd = 0; ex_rd = 0;
    ex_branch_taken = 0;

    phase = "reset_start";
    do_reset_start();
    idle_n(1);

    phase = "load_use_r3";
    s = quiet(); s.mrd = 1; s.rd = 3; s.rs = 3; s.urs = 1; drive(s);
    idle_n(1);
    phase = "load_use_r0";
    s = quiet(); s.mrd = 1; s.rd = 0; s.rs = 0; s.urs = 1; drive(s);
    phase = "load_use_rt_call";
    s = quiet(); s.mrd = 1; s.rd = 5; s.rt = 5; s.urt = 1; s.call = 1; drive(s);
    s.mrd = 0; drive(s);
    s = quiet(); s.ret = 1; drive(s);

    phase = "branch_vs_call";
    s = quiet(); s.br = 1; s.call = 1; drive(s);
    s = quiet(); s.jmp = 1; drive(s);

    phase = "call_overflow";
    for (int i = 0; i < 9; i++) begin s = quiet(); s.call = 1; drive(s); end
    idle_n(5);

    phase = "ret_underflow";
    do_reset_start();
    s = quiet(); s.ret = 1; drive(s);
    idle_n(4);
    s = quiet(); s.start = 1; drive(s);
    idle_n(2);

    phase = "halt_then_reset";
    do_reset_start();
    s = quiet(); s.halt = 1; s.jmp = 1; drive(s);
    idle_n(2);
    s = quiet(); s.rst = 0; drive(s);
    idle_n(2);

    phase = "random";
    for (int seg = 0; seg < 40; seg++) begin
      do_reset_start();
      for (int c = 0; c < 60; c++) begin
        s = quiet();
        s.rst   = ($urandom_range(0, 199) != 0);
        s.start = ($urandom_range(0, 15) == 0);
        s.br    = ($urandom_range(0, 7) == 0);
        s.halt  = ($urandom_range(0, 39) == 0);
        s.call  = ($urandom_range(0, 2) == 0);
        s.ret   = ($urandom_range(0, 3) == 0);
        s.jmp   = ($urandom_range(0, 4) == 0);
        s.mrd   = $urandom_range(0, 1);
        s.urs   = $urandom_range(0, 1);
        s.urt   = $urandom_range(0, 1);
        s.rs    = 3'($urandom_range(0, 3));
        s.rt    = 3'($urandom_range(0, 3));
        s.rd    = 3'($urandom_range(0, 3));
        drive(s);
      end
    end

    @(negedge clk); #1;
    phase = "drain_sb";
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central pipeline control for the 5-stage, 19-bit-instruction core.
- Sequences start, run, drain and halt.
- Resolves load-use stalls, EX-stage branch redirects, and ID-stage jmp/call/ret.
- Drives PC-select, PC/IF_ID write enables, IF_ID/ID_EX flushes and stack push/pop, and tracks call depth.
- Sits beside the controller and replaces the ad-hoc hazard logic.

Parameters:
- STACK_DEPTH, 8: return-stack entries; depth counter is clog2(STACK_DEPTH+1) bits.
- DRAIN_CYCLES, 3: cycles after halt/fault acceptance before HALTED, covering the ID_EX, EX_MEM and MEM_WB stages.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle run request, honoured only in IDLE.
- id_halt  in  1  instruction in ID is halt.
- id_jmp  in  1  instruction in ID is jmp.
- id_call  in  1  instruction in ID is call.
- id_ret  in  1  instruction in ID is ret.
- id_rs  in  3  IF_ID source register 1.
- id_rt  in  3  IF_ID source register 2.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_rd  in  1  ID_EX instruction is a load.
- ex_rd  in  3  ID_EX destination register.
- ex_branch_taken  in  1  branch in EX resolved taken.
- pc_sel  out  2  PC mux select: 00 = pc+1, 01 = jump target, 10 = stack top, 11 = branch target.
- pc_wr  out  1  PC load enable.
- if_id_wr  out  1  IF_ID load enable.
- if_id_flush  out  1  IF_ID loads a bubble.
- id_ex_flush  out  1  ID_EX loads a bubble (control bits zeroed).
- push  out  1  stack push of IF_ID pc+1.
- pop  out  1  stack pop.
- running  out  1  state is RUN.
- halted  out  1  state is HALTED.
- fault  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Registered state: state (IDLE, RUN, DRAIN, HALTED), depth counter, drain counter, fault. All other outputs are combinational from state and inputs, taking effect in the same cycle.
- Reset (rst=0, asynchronous):
  - state=IDLE, depth=0, drain=0, fault=0.
  - Outputs: pc_sel=00, pc_wr=0, if_id_wr=0, if_id_flush=1, id_ex_flush=1, push=0, pop=0, running=0, halted=0.
  - Reset mid-operation abandons all state.
- IDLE: outputs as at reset. start=1 moves to RUN next cycle; otherwise stay in IDLE.
- RUN: the default is pc_sel=00, pc_wr=1, if_id_wr=1, no flush. Exactly one rule applies, in this priority order:
  1. ex_branch_taken: pc_sel=11, pc_wr=1, if_id_flush=1, id_ex_flush=1. The ID instruction is killed, including halt/jmp/call/ret/stall (2-bubble penalty). No push/pop.
  2. id_halt: pc_wr=0, if_id_flush=1. drain <= DRAIN_CYCLES-1; go to DRAIN.
  3. Load-use hazard: ex_mem_rd and ex_rd equals (id_rs with id_uses_rs, or id_rt with id_uses_rt).
     - pc_wr=0, if_id_wr=0, id_ex_flush=1; 1-cycle stall.
     - ID-stage jmp/call/ret wait until the stall clears.
  4. id_call:
     - If depth==STACK_DEPTH: fault <= 1; act as halt (rule 2); no push.
     - Otherwise: pc_sel=01, pc_wr=1, push=1, if_id_flush=1, depth+1.
  5. id_ret:
     - If depth==0: fault <= 1; act as halt; no pop.
     - Otherwise: pc_sel=10, pc_wr=1, pop=1, if_id_flush=1, depth-1.
  6. id_jmp: pc_sel=01, pc_wr=1, if_id_flush=1.
- Multiple ID flags asserted together: priority halt > call > ret > jmp.
- DRAIN:
  - pc_wr=0, if_id_wr=0, if_id_flush=1, id_ex_flush=1. All ID/EX inputs are ignored.
  - drain decrements each cycle; at drain==0 go to HALTED next cycle.
  - Total: DRAIN_CYCLES cycles in DRAIN.
- HALTED: as IDLE outputs but halted=1; start ignored; only rst exits.
- depth never wraps; push and pop are never asserted in the same cycle.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined: register 0 is hardwired zero, so ex_rd==0 never produces a load-use stall.
- Undefined: all eight registers, including r0, participate in hazard comparison.

Test Plan:
- Release rst, hold 2 cycles, pulse start -> next cycle running=1, pc_wr=1, pc_sel=00, no flush; before start if_id_flush=id_ex_flush=1.
- In RUN: ex_mem_rd=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle pc_wr=0, if_id_wr=0, id_ex_flush=1. Repeat with ex_rd=0: stall without ZERO_REG_EN, no stall with it.
- ex_branch_taken=1 together with id_call=1 -> pc_sel=11, both flushes=1, push=0, depth unchanged.
- 8 consecutive id_call (STACK_DEPTH=8) -> 8 pushes; the 9th call -> fault=1, push=0, DRAIN for 3 cycles, then halted=1.
- id_ret at depth 0 -> pop=0, fault=1, halted=1 after 3 DRAIN cycles. A following start pulse leaves halted=1.
- id_halt in RUN -> pc_wr=0 immediately, 3 DRAIN cycles with both flushes=1, then halted=1. Asserting rst mid-DRAIN -> IDLE with all outputs at reset values.
